// File: rtl/pst_if_fetch_queue.sv
// Decoupled instruction-fetch stage: owns the fetch PC and issues word fetches to a
// synchronous-read instruction memory. Responses are buffered in a small FIFO that feeds
// decode through valid/ready. Prioritised redirects squash queued and in-flight fetches.
module pst_if_fetch_queue #(
    parameter int unsigned          ADDR_NBIT   = 10,
    parameter int unsigned          QUEUE_DEPTH = 4,
    parameter int unsigned          NUM_REDIR   = 2,
    parameter logic [ADDR_NBIT-1:0] RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NUM_REDIR-1:0]           redir_vld,
    input  logic [NUM_REDIR*ADDR_NBIT-1:0] redir_pc,
    output logic                           imem_req,
    output logic [ADDR_NBIT-1:0]           imem_addr,
    input  logic [31:0]                    imem_data,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [ADDR_NBIT-1:0]           out_pc,
    output logic [ADDR_NBIT-1:0]           out_pc_4,
    output logic [31:0]                    out_inst
);

    localparam int unsigned          PtrW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned          CntW  = PtrW + 1;
    localparam logic [ADDR_NBIT-1:0] Four  = ADDR_NBIT'(4);
    localparam logic [CntW-1:0]      Depth = CntW'(QUEUE_DEPTH);

    logic [ADDR_NBIT-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic                 inflight_q;
    logic [ADDR_NBIT-1:0] inflight_pc_q;

    logic [ADDR_NBIT-1:0] pc_mem   [QUEUE_DEPTH];
    logic [31:0]          inst_mem [QUEUE_DEPTH];

    logic                 redir_any;
    logic [ADDR_NBIT-1:0] redir_tgt;
    logic                 pop;
    logic                 push;
    logic [CntW-1:0]      occ;
    logic                 issue_ok;

    // Redirect arbitration: scan from the top so the lowest set index is written last.
    always_comb begin
        redir_any = 1'b0;
        redir_tgt = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_vld[i]) begin
                redir_any = 1'b1;
                redir_tgt = redir_pc[i*ADDR_NBIT +: ADDR_NBIT];
            end
        end
        redir_tgt[1:0] = 2'b00;
    end

    assign pop      = out_vld && out_rdy && en;
    // Credit: queued + in-flight after this cycle's pop must leave room for a new response.
    assign occ      = count_q + CntW'(inflight_q) - CntW'(pop);
    assign issue_ok = en && (occ < Depth);
    // A redirect in the response cycle squashes the in-flight (wrong-path) response.
    assign push     = inflight_q && !redir_any;

    // Fetch request generation and next fetch PC.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (redir_any) begin
            // FIFO and in-flight slot are flushed, so only en gates the target fetch.
            imem_req   = en;
            imem_addr  = redir_tgt;
            fetch_pc_d = en ? redir_tgt + Four : redir_tgt;
        end else if (issue_ok) begin
            imem_req   = 1'b1;
            fetch_pc_d = fetch_pc_q + Four;
        end
    end

    // FIFO pointer and occupancy next-state; redirect flushes regardless of push/pop.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redir_any) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d = count_q + CntW'(push) - CntW'(pop);
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            inflight_q    <= imem_req;
            inflight_pc_q <= imem_addr;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            inst_mem[wr_ptr_q] <= imem_data;
        end
    end

    assign out_vld  = (count_q != '0);
    assign out_pc   = pc_mem[rd_ptr_q];
    assign out_pc_4 = pc_mem[rd_ptr_q] + Four;
    assign out_inst = inst_mem[rd_ptr_q];

endmodule

// File: tb/tb_pst_if_fetch_queue.sv
// Scoreboard bench for pst_if_fetch_queue: a cycle model predicts fetch requests and
// queues expected {pc} entries; entries are popped and compared as decode accepts them.
module tb_pst_if_fetch_queue;

    localparam int unsigned AW = 10;
    localparam int unsigned QD = 4;
    localparam int unsigned NR = 2;
    localparam logic [AW-1:0] RPC = 10'h100;

    logic             clk;
    logic             rst;
    logic             en;
    logic [NR-1:0]    redir_vld;
    logic [NR*AW-1:0] redir_pc;
    logic             imem_req;
    logic [AW-1:0]    imem_addr;
    logic [31:0]      imem_data;
    logic             out_vld;
    logic             out_rdy;
    logic [AW-1:0]    out_pc;
    logic [AW-1:0]    out_pc_4;
    logic [31:0]      out_inst;

    pst_if_fetch_queue #(
        .ADDR_NBIT   (AW),
        .QUEUE_DEPTH (QD),
        .NUM_REDIR   (NR),
        .RESET_PC    (RPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .redir_vld (redir_vld),
        .redir_pc  (redir_pc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_pc    (out_pc),
        .out_pc_4  (out_pc_4),
        .out_inst  (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [AW-1:0] pc);
        return 32'hC0DE_0000 ^ {pc, 6'h15, pc, 6'h2A};
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) imem_data <= inst_of(imem_addr);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state.
    logic [AW-1:0] sb[$];
    logic [AW-1:0] m_pc = RPC;
    logic          m_infl = 1'b0;
    logic [AW-1:0] m_infl_pc = '0;
    int            dut_q = 0;
    logic          dut_infl = 1'b0;
    int            phase = 0;
    logic          seen8 = 1'b0;
    logic          seen_wrap = 1'b0;

    logic          r_any, e_vld, e_pop, e_req, d_pop;
    logic [AW-1:0] tgt, e_addr;
    int            occ;

    // Per-cycle checker, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        r_any = 1'b0;
        tgt   = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (redir_vld[i]) begin
                r_any = 1'b1;
                tgt   = redir_pc[i*AW +: AW];
            end
        end
        tgt = tgt & 10'h3FC;

        e_vld = (sb.size() != 0);
        check("out_vld", {31'd0, out_vld}, {31'd0, e_vld});
        if (e_vld && out_vld) begin
            check("out_pc", {22'd0, out_pc}, {22'd0, sb[0]});
            check("out_pc_4", {22'd0, out_pc_4}, {22'd0, sb[0] + 10'd4});
            check("out_inst", out_inst, inst_of(sb[0]));
        end
        e_pop = e_vld && out_rdy && en;
        if (phase == 1 && out_vld && out_rdy && en && out_pc == 10'h008) seen8 = 1'b1;
        if (out_vld && out_pc == 10'h3FC && out_pc_4 == 10'h000) seen_wrap = 1'b1;

        if (rst) begin
            check("rst_req", {31'd0, imem_req}, 32'd0);
            check("rst_addr", {22'd0, imem_addr}, {22'd0, RPC});
            sb.delete();
            m_infl   = 1'b0;
            m_pc     = RPC;
            dut_q    = 0;
            dut_infl = 1'b0;
        end else begin
            if (r_any) begin
                e_req  = en;
                e_addr = tgt;
            end else begin
                occ    = sb.size() + int'(m_infl) - int'(e_pop);
                e_req  = en && (occ < QD);
                e_addr = m_pc;
            end
            check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
            if (e_req) check("imem_addr", {22'd0, imem_addr}, {22'd0, e_addr});

            // Occupancy as implied by the DUT's own request/handshake activity.
            d_pop = out_vld && out_rdy && en;
            if (imem_req && !r_any)
                check("no_overflow", {31'd0, (dut_q + int'(dut_infl) - int'(d_pop)) < QD},
                      32'd1);
            dut_q    = r_any ? 0 : dut_q + int'(dut_infl) - int'(d_pop);
            dut_infl = imem_req;

            if (e_pop) void'(sb.pop_front());
            if (r_any) sb.delete();
            else if (m_infl) sb.push_back(m_infl_pc);
            if (r_any)      m_pc = en ? tgt + 10'd4 : tgt;
            else if (e_req) m_pc = m_pc + 10'd4;
            m_infl    = e_req;
            m_infl_pc = e_addr;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [NR-1:0] v, input logic [AW-1:0] p1,
                            input logic [AW-1:0] p0);
        redir_vld = v;
        redir_pc  = {p1, p0};
    endtask

    int nreq;

    initial begin
        rst = 1'b1; en = 1'b1; out_rdy = 1'b1;
        redir_vld = '0; redir_pc = '0;
        cyc(3);
        rst = 1'b0;
        cyc(8);

        // Backpressure: redirect to 0 and hold decode off.
        out_rdy = 1'b0;
        redirect(2'b01, 10'h0, 10'h0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) nreq++;
            @(posedge clk);
            #1;
            redir_vld = '0;
        end
        check("bp_reqs", nreq, 4);
        out_rdy = 1'b1;
        cyc(8);

        // Redirect to 0x40 the cycle after the request to 0x8.
        redirect(2'b01, 10'h0, 10'h0);
        cyc(1);
        redir_vld = '0;
        cyc(2);
        redirect(2'b01, 10'h0, 10'h040);
        phase = 1;
        cyc(1);
        redir_vld = '0;
        cyc(6);
        phase = 0;
        check("squash_0x8", {31'd0, seen8}, 32'd0);

        // Both sources: source 0 wins.
        redirect(2'b11, 10'h080, 10'h020);
        #1;
        check("redir_prio", {22'd0, imem_addr}, 32'h20);
        cyc(1);
        redir_vld = '0;
        cyc(5);

        // Wrap at the top of the address space.
        redirect(2'b10, 10'h3FE, 10'h111);
        cyc(1);
        redir_vld = '0;
        cyc(6);
        check("wrap_seen", {31'd0, seen_wrap}, 32'd1);

        // Enable drop with a request in flight.
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(8);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            en      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 11) == 0)
                redirect(NR'($urandom_range(1, 3)), AW'($urandom), AW'($urandom));
            else
                redir_vld = '0;
            cyc(1);
        end

        // Reset mid-operation.
        redir_vld = '0; en = 1'b1; out_rdy = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        out_rdy = 1'b1;
        cyc(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
